// File: rtl/txdata_ctrl.sv
// txdata_ctrl: serializer/driver bring-up sequencer and mission data mux.
// Define TXDATA_CTRL_PRBS_EN for PRBS7 training words (default 0101...).
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif
`ifndef DRIVER_CTL_BITS
`define DRIVER_CTL_BITS 4
`endif
`ifndef DCDL_CTRL_BITWIDTH
`define DCDL_CTRL_BITWIDTH 8
`endif

module txdata_ctrl #(
  parameter int DW       = 2**`SERDES_STAGES,
  parameter int DRV_BITS = `DRIVER_CTL_BITS,
  parameter int DL_BITS  = `DCDL_CTRL_BITWIDTH,
  parameter int RST_CYC  = 8,
  parameter int EN_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_load,
  input  logic [DRV_BITS-1:0] cfg_pu_ctl,
  input  logic [DRV_BITS-1:0] cfg_pd_ctlb,
  input  logic [DL_BITS-1:0]  cfg_dl_ctrl,
  input  logic [7:0]          train_len,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DW-1:0]       din,
  output logic                ser_rstb,
  output logic                driver_en,
  output logic                driver_enb,
  output logic [DRV_BITS-1:0] pu_ctl,
  output logic [DRV_BITS-1:0] pd_ctlb,
  output logic [DL_BITS-1:0]  dl_ctrl,
  output logic                link_up
);

  localparam int MAXA = (RST_CYC > EN_CYC) ? RST_CYC : EN_CYC;
  localparam int MAXC = (MAXA > 255) ? MAXA : 255;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OFF, SRST, DRVON, MARK, TRAIN, ACTIVE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0]    tl, tl_n;
  logic [DW-1:0] din_n, train_w;
  logic          drv_on_n;

  assign cnt_inc = cnt + 1'b1;

`ifdef TXDATA_CTRL_PRBS_EN
  logic [6:0] lfsr, lfsr_adv;

  // x^7+x^6+1, one word of bits per TRAIN cycle, bit 0 first
  always_comb begin
    lfsr_adv = lfsr;
    train_w  = '0;
    for (int b = 0; b < DW; b++) begin
      train_w[b] = lfsr_adv[6] ^ lfsr_adv[5];
      lfsr_adv   = {lfsr_adv[5:0], train_w[b]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 7'h7F;
    else if (state_n == MARK)
      lfsr <= 7'h7F;
    else if (state_n == TRAIN)
      lfsr <= lfsr_adv;
  end
`else
  always_comb begin
    train_w = '0;
    for (int b = 0; b < DW; b++)
      train_w[b] = (b % 2 == 0);
  end
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tl_n    = tl;
    unique case (state)
      OFF: begin
        if (en) begin
          state_n = SRST;
          cnt_n   = '0;
        end
      end
      SRST: begin
        if (cnt_inc == CW'(RST_CYC)) begin
          state_n = DRVON;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DRVON: begin
        if (cnt_inc == CW'(EN_CYC)) begin
          state_n = MARK;
          cnt_n   = '0;
          tl_n    = train_len;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      MARK: begin
        if (tl != 8'd0)
          state_n = TRAIN;
        else
          state_n = ACTIVE;
      end
      TRAIN: begin
        if (cnt_inc == CW'(tl)) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ACTIVE: ;
      default: state_n = OFF;
    endcase
    if (state != OFF && !en) begin
      state_n = OFF;
      cnt_n   = '0;
    end
  end

  // Outputs describe the state being entered, so they register with it
  always_comb begin
    din_n = '0;
    unique case (state_n)
      MARK:    din_n = '1;
      TRAIN:   din_n = train_w;
      ACTIVE:  if (state == ACTIVE && in_valid) din_n = in_data;
      default: din_n = '0;
    endcase
  end

  assign drv_on_n = !(state_n inside {OFF, SRST});

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      tl         <= '0;
      din        <= '0;
      ser_rstb   <= 1'b0;
      driver_en  <= 1'b0;
      driver_enb <= 1'b1;
      in_ready   <= 1'b0;
      link_up    <= 1'b0;
      pu_ctl     <= '0;
      pd_ctlb    <= '1;
      dl_ctrl    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tl         <= tl_n;
      din        <= din_n;
      ser_rstb   <= drv_on_n;
      driver_en  <= drv_on_n;
      driver_enb <= !drv_on_n;
      in_ready   <= (state_n == ACTIVE);
      link_up    <= (state_n == ACTIVE);
      if (state == OFF && cfg_load) begin
        pu_ctl  <= cfg_pu_ctl;
        pd_ctlb <= cfg_pd_ctlb;
        dl_ctrl <= cfg_dl_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_txdata_ctrl.sv
// tb_txdata_ctrl: vector table, bring-up sequence and random model check.
// Training word expectations follow TXDATA_CTRL_PRBS_EN when defined.
module tb_txdata_ctrl;

  localparam int DW   = 16;
  localparam int DRVB = 4;
  localparam int DLB  = 8;
  localparam int RC   = 8;
  localparam int EC   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            cfg_load = 1'b0;
  logic [DRVB-1:0] cfg_pu_ctl = '0;
  logic [DRVB-1:0] cfg_pd_ctlb = '0;
  logic [DLB-1:0]  cfg_dl_ctrl = '0;
  logic [7:0]      train_len = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   din;
  logic            ser_rstb, driver_en, driver_enb, link_up;
  logic [DRVB-1:0] pu_ctl, pd_ctlb;
  logic [DLB-1:0]  dl_ctrl;

  always #5 clk = ~clk;

  txdata_ctrl #(
    .DW(DW), .DRV_BITS(DRVB), .DL_BITS(DLB),
    .RST_CYC(RC), .EN_CYC(EC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
    .cfg_pu_ctl(cfg_pu_ctl), .cfg_pd_ctlb(cfg_pd_ctlb),
    .cfg_dl_ctrl(cfg_dl_ctrl), .train_len(train_len),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .ser_rstb(ser_rstb),
    .driver_en(driver_en), .driver_enb(driver_enb),
    .pu_ctl(pu_ctl), .pd_ctlb(pd_ctlb), .dl_ctrl(dl_ctrl),
    .link_up(link_up)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endfunction

  function automatic logic [DW-1:0] trainw(int k);
    logic [DW-1:0] w;
`ifdef TXDATA_CTRL_PRBS_EN
    bit h[$];
    h = '{1, 1, 1, 1, 1, 1, 1};
    for (int i = 7; i < 7 + (k + 1) * DW; i++)
      h.push_back(h[i-7] ^ h[i-6]);
    for (int b = 0; b < DW; b++)
      w[b] = h[7 + k * DW + b];
`else
    for (int b = 0; b < DW; b++)
      w[b] = (b % 2 == 0);
`endif
    return w;
  endfunction

  typedef struct {
    string         nm;
    logic          rst, en, ld, v;
    logic [7:0]    tl;
    logic [DLB-1:0] dl;
    logic [DW-1:0] d;
    logic [DW-1:0] e_din;
    logic          e_up, e_drv, e_rdy;
    logic [DLB-1:0] e_dl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, int r, int e, int ld, int v,
                              int tl, int dl, logic [DW-1:0] d,
                              logic [DW-1:0] edin, int eup, int edrv,
                              int erdy, int edl);
    vec_t x;
    x.nm = nm; x.rst = 1'(r); x.en = 1'(e); x.ld = 1'(ld);
    x.v = 1'(v); x.tl = 8'(tl); x.dl = DLB'(dl); x.d = d;
    x.e_din = edin; x.e_up = 1'(eup); x.e_drv = 1'(edrv);
    x.e_rdy = 1'(erdy); x.e_dl = DLB'(edl);
    tbl.push_back(x);
  endfunction

  typedef struct packed {
    logic [DW-1:0]   din;
    logic            rstb, drv, drvb, rdy, lu;
    logic [DRVB-1:0] pu, pd;
    logic [DLB-1:0]  dl;
  } obs_t;

  obs_t m;
  bit   m_on = 0;
  int   q[$];

  // Schedule model: bring-up is a queue of phase tokens, ACTIVE when empty
  task automatic model_step();
    obs_t n;
    int k;
    n = m;
    if (rst) begin
      m_on = 0; q.delete();
      n = '0; n.drvb = 1'b1; n.pd = '1;
    end else begin
      if (!m_on && cfg_load) begin
        n.pu = cfg_pu_ctl; n.pd = cfg_pd_ctlb; n.dl = cfg_dl_ctrl;
      end
      if (!en) begin
        m_on = 0; q.delete();
        n.din = '0; n.rstb = 0; n.drv = 0;
        n.drvb = 1; n.rdy = 0; n.lu = 0;
      end else begin
        if (!m_on) begin
          m_on = 1;
          for (int i = 0; i < RC; i++) q.push_back(0);
          for (int i = 0; i < EC; i++) q.push_back(1);
          q.push_back(2);
        end
        n.rdy = 0; n.lu = 0; n.rstb = 1; n.drv = 1; n.drvb = 0;
        if (q.size() == 0) begin
          n.rdy = 1; n.lu = 1;
          n.din = (m.rdy && in_valid) ? in_data : '0;
        end else begin
          k = q.pop_front();
          if (k == 0) begin
            n.rstb = 0; n.drv = 0; n.drvb = 1; n.din = '0;
          end else if (k == 1) begin
            n.din = '0;
          end else if (k == 2) begin
            n.din = '1;
            for (int j = 0; j < int'(train_len); j++) q.push_back(3 + j);
          end else begin
            n.din = trainw(k - 3);
          end
        end
      end
    end
    m = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    cfg_pu_ctl = 4'h3;
    cfg_pd_ctlb = 4'hC;

    add("rst0", 1,0,0,0, 0,0,'0, '0,0,0,0,0);
    add("rst1", 1,0,0,0, 0,0,'0, '0,0,0,0,0);
    add("off",  0,0,0,0, 3,0,'0, '0,0,0,0,0);
    add("en_ld",0,1,1,0, 3,7,'0, '0,0,0,0,7);
    for (int i = 0; i < RC - 1; i++)
      add("srst", 0,1,0,0, 3,0,'0, '0,0,0,0,7);
    for (int i = 0; i < EC; i++)
      add("drvon",0,1,0,0, 3,0,'0, '0,1,1,0,7);
    add("mark", 0,1,0,0, 3,0,'0, '1,1,1,0,7);
    for (int k = 0; k < 3; k++)
      add("train",0,1,0,0, 3,0,'0, trainw(k),1,1,0,7);
    add("act0", 0,1,0,0, 3,0,'0, '0,1,1,1,7);
    add("d1234",0,1,0,1, 3,0,16'h1234, 16'h1234,1,1,1,7);
    add("dbeef",0,1,0,1, 3,0,16'hBEEF, 16'hBEEF,1,1,1,7);
    add("idle", 0,1,0,0, 3,0,16'h7777, '0,1,1,1,7);
    add("ld_act",0,1,1,0, 3,5,'0, '0,1,1,1,7);
    add("en_off",0,0,0,1, 3,0,16'hAAAA, '0,0,0,0,7);
    add("ld_off",0,0,1,0, 0,5,'0, '0,0,0,0,5);
    for (int i = 0; i < RC; i++)
      add("srst_t0",0,1,0,0, 0,0,'0, '0,0,0,0,5);
    for (int i = 0; i < EC; i++)
      add("drv_t0",0,1,0,0, 0,0,'0, '0,1,1,0,5);
    add("mark_t0",0,1,0,0, 0,0,'0, '1,1,1,0,5);
    add("t0_act", 0,1,0,0, 5,0,'0, '0,1,1,1,5);
    add("dA5A5",  0,1,0,1, 5,0,16'hA5A5, 16'hA5A5,1,1,1,5);
    add("rst_act",1,1,1,1, 5,9,16'hA5A5, '0,0,0,0,0);
    for (int i = 0; i < RC; i++)
      add("srst_b",0,1,0,0, 3,0,'0, '0,0,0,0,0);
    for (int i = 0; i < EC; i++)
      add("drv_b", 0,1,0,0, 3,0,'0, '0,1,1,0,0);
    add("mark_b", 0,1,0,0, 3,0,'0, '1,1,1,0,0);
    add("tw1_b",  0,1,0,0, 3,0,'0, trainw(0),1,1,0,0);
    add("tw2_b",  0,1,0,0, 3,0,'0, trainw(1),1,1,0,0);
    add("drop",   0,0,0,0, 3,0,'0, '0,0,0,0,0);
    for (int i = 0; i < RC; i++)
      add("resrst",0,1,0,0, 3,0,'0, '0,0,0,0,0);
    add("redrv",  0,1,0,0, 3,0,'0, '0,1,1,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; cfg_load = tbl[i].ld;
      in_valid = tbl[i].v; train_len = tbl[i].tl;
      cfg_dl_ctrl = tbl[i].dl; in_data = tbl[i].d;
      step();
      check(tbl[i].nm,
        {din, ser_rstb, driver_en, driver_enb, in_ready, link_up, dl_ctrl},
        {tbl[i].e_din, tbl[i].e_up, tbl[i].e_drv, ~tbl[i].e_drv,
         tbl[i].e_rdy, tbl[i].e_rdy, tbl[i].e_dl});
    end

    // Phase lengths measured live; train_len changed after MARK entry
    @(negedge clk);
    rst = 1; en = 0; cfg_load = 0; in_valid = 0;
    @(negedge clk);
    rst = 0; en = 1; train_len = 8'd2;
    step();
    c = 0;
    while (!ser_rstb && c < 50) begin c++; step(); end
    check("srst_len", 64'(c), 64'(RC));
    c = 0;
    while (driver_en && din == '0 && c < 50) begin c++; step(); end
    check("drvon_len", 64'(c), 64'(EC));
    check("mark_word", 64'(din), 64'(16'hFFFF));
    @(negedge clk);
    train_len = 8'd7;
    step();
    c = 0;
    while (!link_up && c < 50) begin c++; step(); end
    check("train_len_latched", 64'(c), 64'd2);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      if (i == 0) en = 1'b1;
      else if ($urandom_range(0, 79) == 0) en = ~en;
      cfg_load = ($urandom_range(0, 7) == 0);
      cfg_pu_ctl = DRVB'($urandom);
      cfg_pd_ctlb = DRVB'($urandom);
      cfg_dl_ctrl = DLB'($urandom);
      train_len = 8'($urandom_range(0, 4));
      in_valid = 1'($urandom);
      in_data = DW'($urandom);
      @(posedge clk);
      model_step();
      #1;
      check("rand",
        64'({din, ser_rstb, driver_en, driver_enb, in_ready, link_up,
             pu_ctl, pd_ctlb, dl_ctrl}),
        64'(m));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/txdata_ctrl.md
TXDATA_CTRL -- requirements
Module: txdata_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 2**`SERDES_STAGES, serializer word width; DRV_BITS, default `DRIVER_CTL_BITS, driver strength code width; DL_BITS, default `DCDL_CTRL_BITWIDTH, delay-line code width; RST_CYC, default 8, serializer reset hold cycles; EN_CYC, default 4, driver settle cycles.
REQ-002 The block SHALL use one clock, clk (the word clock, slowest serializer clock), and one synchronous active-high reset, rst.
REQ-003 Ports SHALL be:
- clk  in  1  word clock
- rst  in  1  synchronous active-high reset
- en  in  1  link enable
- cfg_load  in  1  latch cfg_* into output registers
- cfg_pu_ctl  in  DRV_BITS  pull-up code
- cfg_pd_ctlb  in  DRV_BITS  pull-down code, active-low
- cfg_dl_ctrl  in  DL_BITS  delay-line code
- train_len  in  8  training word count
- in_data  in  DW  mission data
- in_valid  in  1  mission data valid
- in_ready  out  1  mission data accepted when in_valid&in_ready
- din  out  DW  word to serializer
- ser_rstb  out  1  serializer/clock-divider reset, active-low
- driver_en, driver_enb  out  1 each  driver enable pair
- pu_ctl, pd_ctlb  out  DRV_BITS  driver codes
- dl_ctrl  out  DL_BITS  delay-line code
- link_up  out  1  high in ACTIVE

Function
REQ-004 FSM states SHALL be OFF, SRST, DRVON, MARK, TRAIN, ACTIVE; all outputs registered.
REQ-005 OFF: ser_rstb=0, driver_en=0, driver_enb=1, din=0, in_ready=0; en=1 -> SRST next cycle.
REQ-006 SRST: ser_rstb=0 for exactly RST_CYC cycles, then DRVON; ser_rstb=1 from DRVON entry onward.
REQ-007 DRVON: driver_en=1, driver_enb=0, din=0 for exactly EN_CYC cycles, then MARK.
REQ-008 MARK: din = all-ones for exactly one cycle, then TRAIN if train_len!=0, else ACTIVE.
REQ-009 TRAIN: din = training pattern word for exactly train_len cycles, then ACTIVE.
REQ-010 ACTIVE: in_ready=1, link_up=1; when in_valid=1, din=in_data the following cycle; when in_valid=0, din=0 the following cycle (idle word).
REQ-011 Latency in_data->din SHALL be exactly one cycle; no buffering; in_ready SHALL never be 1 outside ACTIVE.
REQ-012 en=0 in any non-OFF state SHALL force OFF next cycle: driver_en=0, driver_enb=1, ser_rstb=0, din=0, in_ready=0; the word in flight when en falls is dropped.
REQ-013 en re-asserted SHALL restart full sequence from SRST; no state is skipped.
REQ-014 cfg_load SHALL update pu_ctl, pd_ctlb, dl_ctrl next cycle only in OFF; cfg_load in any other state SHALL be ignored.
REQ-015 en and cfg_load both asserted in OFF: codes SHALL load and FSM SHALL enter SRST on the same edge.
REQ-016 driver_enb SHALL equal ~driver_en every cycle.
REQ-017 Internal counters SHALL be sized to hold max(RST_CYC, EN_CYC, 255) without wrap; train_len SHALL be sampled on MARK entry, later changes ignored until next sequence.

Reset
REQ-018 rst=1 SHALL give, next edge: state OFF, din=0, ser_rstb=0, driver_en=0, driver_enb=1, in_ready=0, link_up=0, pu_ctl=0, pd_ctlb=all-ones, dl_ctrl=0, counters=0.
REQ-019 rst SHALL take priority over en and cfg_load, including mid-sequence.

Configuration
REQ-020 Macro TXDATA_CTRL_PRBS_EN defined: training word SHALL be DW consecutive bits of PRBS7 (x^7+x^6+1, seed 7'h7F loaded on MARK entry), bit 0 earliest in time; undefined: training word SHALL be alternating 0101..., i.e. din[0]=1.

Verification
REQ-021 rst, then en=1, train_len=3, in_valid=0 -> ser_rstb low 8 cycles after OFF exit, driver_en high 4 cycles with din=0, one all-ones word, 3 training words, then link_up=1.
REQ-022 ACTIVE, in_valid=1 with in_data sequence 16'h1234, 16'hBEEF, then in_valid=0 -> din=16'h1234, 16'hBEEF, 16'h0000 each one cycle later.
REQ-023 en dropped during TRAIN word 2 -> next cycle driver_en=0, ser_rstb=0, din=0; en=1 again -> full 8-cycle SRST repeated.
REQ-024 cfg_load with cfg_dl_ctrl=5 in ACTIVE -> dl_ctrl unchanged; same in OFF -> dl_ctrl=5 next cycle.
REQ-025 train_len=0 -> MARK followed directly by ACTIVE; with TXDATA_CTRL_PRBS_EN, DW=16, train_len=2 -> first training word matches reference PRBS7 model from seed 7'h7F.
REQ-026 rst asserted in ACTIVE with in_valid=1 -> all outputs at REQ-018 values next cycle, in_ready=0.
